alu_issue_stage: RTL and testbench

- Sequential front-end placed directly upstream of the combinational 32-bit ALU (a/b/cin/sel in; f/cout out).
- Accepts operation commands through a valid/ready handshake and buffers them in a FIFO.
- Presents the FIFO head to the ALU, then captures the ALU result, carry, zero flag and tag into an output register with its own valid/ready handshake.

---
 rtl/alu_issue_stage.sv | 144 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage in front of a combinational 32-bit ALU: command FIFO, ALU drive, result register.
// Optional result-handshake counter (op_count_o) enabled by defining ALU_ISSUE_STATS_EN.
module alu_issue_stage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [31:0]              cmd_a_i,
    input  logic [31:0]              cmd_b_i,
    input  logic                     cmd_cin_i,
    input  logic [3:0]               cmd_sel_i,
    input  logic [TAG_W-1:0]         cmd_tag_i,
    output logic [31:0]              alu_a_o,
    output logic [31:0]              alu_b_o,
    output logic                     alu_cin_o,
    output logic [3:0]               alu_sel_o,
    input  logic [31:0]              alu_f_i,
    input  logic                     alu_cout_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [31:0]              res_f_o,
    output logic                     res_cout_o,
    output logic                     res_zero_o,
    output logic [TAG_W-1:0]         res_tag_o,
    output logic [$clog2(DEPTH):0]   level_o
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]              op_count_o
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned EW = 32 + 32 + 1 + 4 + TAG_W;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [EW-1:0]      mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]      level_q, level_d;
    logic               push, pop;

    logic [EW-1:0]      head;
    logic [31:0]        head_a, head_b;
    logic               head_cin;
    logic [3:0]         head_sel;
    logic [TAG_W-1:0]   head_tag;

    logic               res_valid_q;
    logic [31:0]        res_f_q;
    logic               res_cout_q, res_zero_q;
    logic [TAG_W-1:0]   res_tag_q;

    // Ready depends on registered occupancy only, never on res_ready_i.
    assign cmd_ready_o = (level_q != FULL);
    assign push        = cmd_valid_i & cmd_ready_o;
    assign pop         = (level_q != '0) & (~res_valid_q | res_ready_i);

    assign head = mem_q[rd_ptr_q];
    assign {head_tag, head_sel, head_cin, head_b, head_a} = head;

    always_comb begin
        alu_a_o   = '0;
        alu_b_o   = '0;
        alu_cin_o = 1'b0;
        alu_sel_o = '0;
        if (level_q != '0) begin
            alu_a_o   = head_a;
            alu_b_o   = head_b;
            alu_cin_o = head_cin;
            alu_sel_o = head_sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_tag_i, cmd_sel_i, cmd_cin_i, cmd_b_i, cmd_a_i};
        end
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_q <= 1'b0;
            res_f_q     <= '0;
            res_cout_q  <= 1'b0;
            res_zero_q  <= 1'b0;
            res_tag_q   <= '0;
        end else if (pop) begin
            res_valid_q <= 1'b1;
            res_f_q     <= alu_f_i;
            res_cout_q  <= alu_cout_i;
            res_zero_q  <= (alu_f_i == 32'd0);
            res_tag_q   <= head_tag;
        end else if (res_ready_i) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_f_o     = res_f_q;
    assign res_cout_o  = res_cout_q;
    assign res_zero_o  = res_zero_q;
    assign res_tag_o   = res_tag_q;
    assign level_o     = level_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_count_q <= '0;
        end else if (res_valid_q && res_ready_i && (op_count_q != 16'hFFFF)) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count_o = op_count_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized self-checking bench for alu_issue_stage; models the ALU and a queue-level reference.
module tb_alu_issue_stage;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b1;
    logic               cmd_valid_i = 1'b0;
    logic               cmd_ready_o;
    logic [31:0]        cmd_a_i = '0;
    logic [31:0]        cmd_b_i = '0;
    logic               cmd_cin_i = 1'b0;
    logic [3:0]         cmd_sel_i = '0;
    logic [TAG_W-1:0]   cmd_tag_i = '0;
    logic [31:0]        alu_a_o;
    logic [31:0]        alu_b_o;
    logic               alu_cin_o;
    logic [3:0]         alu_sel_o;
    logic [31:0]        alu_f_i;
    logic               alu_cout_i;
    logic               res_valid_o;
    logic               res_ready_i = 1'b0;
    logic [31:0]        res_f_o;
    logic               res_cout_o;
    logic               res_zero_o;
    logic [TAG_W-1:0]   res_tag_o;
    logic [LW-1:0]      level_o;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0]        op_count_o;
`endif

    alu_issue_stage #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_a_i     (cmd_a_i),
        .cmd_b_i     (cmd_b_i),
        .cmd_cin_i   (cmd_cin_i),
        .cmd_sel_i   (cmd_sel_i),
        .cmd_tag_i   (cmd_tag_i),
        .alu_a_o     (alu_a_o),
        .alu_b_o     (alu_b_o),
        .alu_cin_o   (alu_cin_o),
        .alu_sel_o   (alu_sel_o),
        .alu_f_i     (alu_f_i),
        .alu_cout_i  (alu_cout_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_f_o     (res_f_o),
        .res_cout_o  (res_cout_o),
        .res_zero_o  (res_zero_o),
        .res_tag_o   (res_tag_o),
`ifdef ALU_ISSUE_STATS_EN
        .op_count_o  (op_count_o),
`endif
        .level_o     (level_o)
    );

    always #5 clk_i = ~clk_i;

    // Stand-in for the downstream combinational ALU: {cout, f}.
    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic [3:0] sel);
        case (sel)
            4'b0001: return {1'b0, a} + {1'b0, b} + 33'(cin);
            4'b0010: return {1'b0, a} + {1'b0, ~b} + 33'(cin);
            4'b0100: return {1'b0, a & b};
            4'b0101: return {1'b0, a | b};
            4'b0110: return {1'b0, a ^ b};
            4'b1000: return {1'b0, a << b[4:0]};
            4'b1001: return {1'b0, a >> b[4:0]};
            default: return {1'b0, a};
        endcase
    endfunction

    always_comb {alu_cout_i, alu_f_i} = alu_ref(alu_a_o, alu_b_o, alu_cin_o, alu_sel_o);

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic             cin;
        logic [3:0]       sel;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    cmd_t             mq[$];
    logic             m_rv;
    logic [31:0]      m_f;
    logic             m_cout, m_zero;
    logic [TAG_W-1:0] m_tag;
    logic [15:0]      m_cnt;
    logic             last_push;
    logic             track_order;
    int               next_tag;
    int               n_total = 0;
    int               n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("level", 64'(level_o), 64'(mq.size()));
        check("cmd_ready", 64'(cmd_ready_o), 64'(mq.size() != DEPTH));
        check("res_valid", 64'(res_valid_o), 64'(m_rv));
        check("res_f", 64'(res_f_o), 64'(m_f));
        check("res_cout", 64'(res_cout_o), 64'(m_cout));
        check("res_zero", 64'(res_zero_o), 64'(m_zero));
        check("res_tag", 64'(res_tag_o), 64'(m_tag));
        check("alu_a", 64'(alu_a_o), mq.size() != 0 ? 64'(mq[0].a) : 64'd0);
        check("alu_b", 64'(alu_b_o), mq.size() != 0 ? 64'(mq[0].b) : 64'd0);
        check("alu_cin", 64'(alu_cin_o), mq.size() != 0 ? 64'(mq[0].cin) : 64'd0);
        check("alu_sel", 64'(alu_sel_o), mq.size() != 0 ? 64'(mq[0].sel) : 64'd0);
`ifdef ALU_ISSUE_STATS_EN
        check("op_count", 64'(op_count_o), 64'(m_cnt));
`endif
    endtask

    // Drive one cycle of inputs, advance the reference, then compare after the edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [3:0] sel, input logic [TAG_W-1:0] tag,
                        input logic rr);
        cmd_t        c;
        logic        do_push, do_pop;
        logic [32:0] r;
        cmd_valid_i = v;
        cmd_a_i     = a;
        cmd_b_i     = b;
        cmd_cin_i   = cin;
        cmd_sel_i   = sel;
        cmd_tag_i   = tag;
        res_ready_i = rr;
        do_push = v && (mq.size() != DEPTH);
        do_pop  = (mq.size() != 0) && (!m_rv || rr);
        if (m_rv && rr) begin
            if (m_cnt != 16'hFFFF) m_cnt++;
            if (track_order) begin
                check("order", 64'(res_tag_o), 64'(next_tag));
                next_tag++;
            end
        end
        if (do_pop) begin
            c      = mq.pop_front();
            r      = alu_ref(c.a, c.b, c.cin, c.sel);
            m_f    = r[31:0];
            m_cout = r[32];
            m_zero = (r[31:0] == 32'd0);
            m_tag  = c.tag;
            m_rv   = 1'b1;
        end else if (rr) begin
            m_rv = 1'b0;
        end
        if (do_push) mq.push_back('{a: a, b: b, cin: cin, sel: sel, tag: tag});
        last_push = do_push;
        @(posedge clk_i);
        #1;
        check_all();
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, '0, rr);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        mq.delete();
        m_rv = 1'b0; m_f = '0; m_cout = 1'b0; m_zero = 1'b0; m_tag = '0; m_cnt = '0;
        cmd_valid_i = 1'b0;
        res_ready_i = 1'b0;
        #1;
        check_all();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_all();
    endtask

    function automatic logic [3:0] rand_sel();
        logic [3:0] sels [8];
        sels = '{4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b1000, 4'b1001, 4'b1111};
        return sels[$urandom_range(0, 7)];
    endfunction

    task automatic rand_step(input logic v, input logic [TAG_W-1:0] tag, input logic rr);
        logic [31:0] a, b;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        step(v, a, b, 1'($urandom_range(0, 1)), rand_sel(), tag, rr);
    endtask

    initial begin
        int sent;
        int budget;
        track_order = 1'b0;
        next_tag    = 0;
        last_push   = 1'b0;
        #2;
        do_reset();
        check("ready_after_reset", 64'(cmd_ready_o), 64'd1);

        // Add, then two cycles later the result.
        step(1'b1, 32'hA5A5F0F0, 32'h0F0F5A5A, 1'b0, 4'b0001, 4'd1, 1'b1);
        idle(1'b1);
        check("add_f", 64'(res_f_o), 64'hB4B54B4A);
        check("add_valid", 64'(res_valid_o), 64'd1);
        check("add_cout", 64'(res_cout_o), 64'd0);
        check("add_tag", 64'(res_tag_o), 64'd1);

        step(1'b1, 32'hA5A5F0F0, 32'h0F0F5A5A, 1'b1, 4'b0010, 4'd2, 1'b1);
        idle(1'b1);
        check("sub_f", 64'(res_f_o), 64'h96969696);
        check("sub_cout", 64'(res_cout_o), 64'd1);
        step(1'b1, 32'h12345678, 32'h12345678, 1'b1, 4'b0010, 4'd3, 1'b1);
        idle(1'b1);
        check("zero_f", 64'(res_f_o), 64'd0);
        check("zero_flag", 64'(res_zero_o), 64'd1);
        check("zero_cout", 64'(res_cout_o), 64'd1);

        // Back-to-back logic ops.
        step(1'b1, 32'hA5A5F0F0, 32'h0F0F5A5A, 1'b0, 4'b0100, 4'd2, 1'b1);
        step(1'b1, 32'hA5A5F0F0, 32'h0F0F5A5A, 1'b0, 4'b0101, 4'd3, 1'b1);
        check("and_f", 64'(res_f_o), 64'h05055050);
        check("and_tag", 64'(res_tag_o), 64'd2);
        step(1'b1, 32'hA5A5F0F0, 32'h0F0F5A5A, 1'b0, 4'b0110, 4'd4, 1'b1);
        check("or_f", 64'(res_f_o), 64'hAFAFFAFA);
        check("or_tag", 64'(res_tag_o), 64'd3);
        idle(1'b1);
        check("xor_f", 64'(res_f_o), 64'hAAAAAAAA);
        check("xor_tag", 64'(res_tag_o), 64'd4);
        idle(1'b1);
        idle(1'b1);

        // Fill with consumer stalled: DEPTH queued plus one held.
        for (int i = 0; i <= DEPTH; i++) rand_step(1'b1, TAG_W'(i), 1'b0);
        check("full_ready", 64'(cmd_ready_o), 64'd0);
        check("full_level", 64'(level_o), 64'(DEPTH));
        check("full_held_tag", 64'(res_tag_o), 64'd0);
        rand_step(1'b1, 4'd9, 1'b0);
        rand_step(1'b1, 4'd9, 1'b0);
        check("stall_tag", 64'(res_tag_o), 64'd0);
        check("stall_valid", 64'(res_valid_o), 64'd1);
        idle(1'b1);
        check("ready_after_pop", 64'(cmd_ready_o), 64'd1);
        check("drain_tag1", 64'(res_tag_o), 64'd1);
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

        // Six commands through random stalls on both sides; tags must come out 0..5.
        track_order = 1'b1;
        next_tag    = 0;
        sent        = 0;
        budget      = 0;
        while ((sent < 6 || mq.size() != 0 || m_rv) && budget < 300) begin
            rand_step(1'b1 && (sent < 6) && ($urandom_range(0, 2) != 0), TAG_W'(sent),
                      1'($urandom_range(0, 2) != 0));
            if (last_push) sent++;
            budget++;
        end
        check("wrap_budget", 64'(budget < 300), 64'd1);
        check("wrap_count", 64'(next_tag), 64'd6);
        track_order = 1'b0;

        // Reset in the middle of draining.
        for (int i = 0; i < 4; i++) rand_step(1'b1, TAG_W'(i), 1'b0);
        rand_step(1'b1, 4'd7, 1'b1);
        check("pre_reset_level", 64'(level_o), 64'd3);
        do_reset();
        check("rst_level", 64'(level_o), 64'd0);
        check("rst_valid", 64'(res_valid_o), 64'd0);
        check("rst_alu_a", 64'(alu_a_o), 64'd0);

        // Long random soak.
        for (int i = 0; i < 400; i++) begin
            rand_step(1'($urandom_range(0, 3) != 0), TAG_W'($urandom),
                      1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        check("end_empty", 64'(level_o), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
